// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Issues one word-aligned fetch at a time over a valid/ready memory port,
// registers the returned word with its PC, and holds it while decode stalls.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc                  fetch address from decode's PC register
//   stall_in, flush     downstream stall; redirect (discard in-flight fetch)
//   imem_req_*          request channel (valid/ready, word-aligned address)
//   imem_rsp_*          response channel (single-cycle pulse, no backpressure)
//   i_fetch, fetch_pc   instruction and its address to decode
//   fetch_valid         i_fetch holds a real instruction
//   pc_hold             decode must not advance pc this cycle
//   timeout_err         sticky: a response took longer than TIMEOUT cycles
//   misalign_err        sticky: a pc with pc[1:0]!=0 was issued
module fetch_stage #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned CNT_W    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        stall_in,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] i_fetch,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        pc_hold,
   output logic        timeout_err,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      ISSUE    = 2'd0,
      WAIT_RSP = 2'd1,
      HOLD     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state;
   logic             req_q;
   logic             drop;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [31:0]      addr_q;
   logic             accept;
   logic             capture;

   // Request is withdrawn while flush is high so the handshake never completes
   // on a redirect; the address follows pc until it is accepted.
   assign imem_req_valid = req_q & ~flush;
   assign imem_req_addr  = imem_req_valid ? {pc[31:2], 2'b00} : 32'h0;
   assign accept         = imem_req_valid & imem_req_ready;

   // A response is kept only if it was not cancelled by an earlier or same-cycle flush.
   assign capture = (state == WAIT_RSP) & imem_rsp_valid & ~drop & ~flush;

   // Decode may advance pc only while the fresh, unstalled word is being captured,
   // so the next request already sees the new pc.
   assign pc_hold = ~(capture & ~stall_in);

   // Saturating wait counter.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // Fetch FSM with registered instruction outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ISSUE;
         req_q        <= 1'b0;
         drop         <= 1'b0;
         cnt          <= '0;
         addr_q       <= 32'h0;
         i_fetch      <= NOP_WORD;
         fetch_pc     <= 32'h0;
         fetch_valid  <= 1'b0;
         timeout_err  <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         // A presented word is consumed after one cycle unless it is stall-held.
         if (!((state == HOLD) && stall_in && !flush)) begin
            fetch_valid <= 1'b0;
            i_fetch     <= NOP_WORD;
         end

         case (state)
            ISSUE: begin
               if (accept) begin
                  state  <= WAIT_RSP;
                  req_q  <= 1'b0;
                  cnt    <= '0;
                  drop   <= 1'b0;
                  addr_q <= pc;
                  if (pc[1:0] != 2'b00) misalign_err <= 1'b1;
               end else begin
                  req_q <= 1'b1;
               end
            end

            WAIT_RSP: begin
               if (imem_rsp_valid) begin
                  drop <= 1'b0;
                  if (capture) begin
                     i_fetch     <= imem_rsp_data;
                     fetch_pc    <= addr_q;
                     fetch_valid <= 1'b1;
                     state       <= stall_in ? HOLD : ISSUE;
                     req_q       <= ~stall_in;
                  end else begin
                     state <= ISSUE;
                     req_q <= 1'b1;
                  end
               end else begin
                  if (flush) drop <= 1'b1;
                  cnt <= cnt_inc;
                  if (cnt_inc >= TIMEOUT_C) timeout_err <= 1'b1;
               end
            end

            HOLD: begin
               if (flush || !stall_in) begin
                  state <= ISSUE;
                  req_q <= 1'b1;
               end
            end

            default: begin
               state <= ISSUE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam int          TMO = 64;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        stall_in;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] i_fetch;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        pc_hold;
   logic        timeout_err;
   logic        misalign_err;

   int n_checks;
   int n_errors;

   // Reference model: what the stage owes decode and memory.
   bit          m_req;      // a request should be offered
   bit          m_busy;     // one request is outstanding
   bit          m_drop;     // outstanding response was cancelled by flush
   bit          m_stalled;  // presented word is held by stall
   int          m_waited;
   logic [31:0] m_addr;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   bit          m_valid;
   bit          m_terr;
   bit          m_merr;

   // Memory responder used by the random phase.
   int          pend;
   logic [31:0] pend_data;

   fetch_stage #(.NOP_WORD(NOP), .TIMEOUT(TMO), .CNT_W(7)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .stall_in       (stall_in),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .i_fetch        (i_fetch),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .pc_hold        (pc_hold),
      .timeout_err    (timeout_err),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_req = 0; m_busy = 0; m_drop = 0; m_stalled = 0; m_waited = 0;
      m_addr = 0; m_instr = NOP; m_pc = 0; m_valid = 0; m_terr = 0; m_merr = 0;
   endtask

   // Apply this cycle's inputs and compare every output with the model.
   task automatic drive(input logic [31:0] p, input logic st, input logic fl,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      logic        e_req;
      logic        e_hold;
      logic [31:0] e_addr;
      pc = p; stall_in = st; flush = fl; imem_req_ready = rdy;
      imem_rsp_valid = rv; imem_rsp_data = rd;
      #1;
      e_req  = m_req && !fl;
      e_addr = e_req ? (p & 32'hFFFF_FFFC) : 32'h0;
      e_hold = !(m_busy && rv && !m_drop && !fl && !st);
      check("req_valid",    32'(imem_req_valid), 32'(e_req));
      check("req_addr",     imem_req_addr,       e_addr);
      check("pc_hold",      32'(pc_hold),        32'(e_hold));
      check("i_fetch",      i_fetch,             m_instr);
      check("fetch_pc",     fetch_pc,            m_pc);
      check("fetch_valid",  32'(fetch_valid),    32'(m_valid));
      check("timeout_err",  32'(timeout_err),    32'(m_terr));
      check("misalign_err", 32'(misalign_err),   32'(m_merr));
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic tick();
      bit acc;
      acc = m_req && !flush && imem_req_ready;
      if (!(m_stalled && stall_in && !flush)) begin
         m_valid = 0;
         m_instr = NOP;
      end
      if (acc) begin
         m_req = 0; m_busy = 1; m_drop = 0; m_waited = 0; m_addr = pc;
         if (pc[1:0] != 2'b00) m_merr = 1;
      end else if (m_busy) begin
         if (imem_rsp_valid) begin
            m_busy = 0;
            if (m_drop || flush) begin
               m_drop = 0;
               m_req  = 1;
            end else begin
               m_valid = 1; m_instr = imem_rsp_data; m_pc = m_addr;
               if (stall_in) m_stalled = 1;
               else m_req = 1;
            end
         end else begin
            if (flush) m_drop = 1;
            m_waited++;
            if (m_waited >= TMO) m_terr = 1;
         end
      end else if (m_stalled) begin
         if (flush || !stall_in) begin
            m_stalled = 0;
            m_req = 1;
         end
      end else begin
         m_req = 1;
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
   task automatic do_reset();
      flush = 0; imem_req_ready = 0; imem_rsp_valid = 0; stall_in = 0;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_req_valid",   32'(imem_req_valid), 32'h0);
      check("rst_req_addr",    imem_req_addr,       32'h0);
      check("rst_i_fetch",     i_fetch,             NOP);
      check("rst_fetch_pc",    fetch_pc,            32'h0);
      check("rst_fetch_valid", 32'(fetch_valid),    32'h0);
      check("rst_pc_hold",     32'(pc_hold),        32'h1);
      check("rst_timeout",     32'(timeout_err),    32'h0);
      check("rst_misalign",    32'(misalign_err),   32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; pend = 0; pend_data = 0;
      rst = 0; pc = 0; stall_in = 0; flush = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Basic fetch: accept at 0x40, response next cycle.
      drive(32'h40, 0, 0, 0, 0, 0); tick();
      drive(32'h40, 0, 0, 1, 0, 0);
      check("t1_addr", imem_req_addr, 32'h40);
      tick();
      drive(32'h40, 0, 0, 0, 1, 32'h2408_0005);
      check("t1_pc_hold", 32'(pc_hold), 32'h0);
      tick();
      drive(32'h44, 0, 0, 0, 0, 0);
      check("t1_i_fetch", i_fetch, 32'h2408_0005);
      check("t1_fetch_pc", fetch_pc, 32'h40);
      check("t1_valid", 32'(fetch_valid), 32'h1);
      tick();
      drive(32'h44, 0, 0, 0, 0, 0);
      check("t1_nop", i_fetch, NOP);
      check("t1_valid_off", 32'(fetch_valid), 32'h0);
      tick();

      // Five-cycle memory latency.
      drive(32'h44, 0, 0, 1, 0, 0); tick();
      for (int i = 1; i <= 4; i++) begin
         drive(32'h44, 0, 0, 0, 0, 0);
         check("t2_valid", 32'(fetch_valid), 32'h0);
         check("t2_nop", i_fetch, NOP);
         check("t2_hold", 32'(pc_hold), 32'h1);
         check("t2_tmo", 32'(timeout_err), 32'h0);
         tick();
      end
      drive(32'h44, 0, 0, 0, 1, 32'h2409_0007); tick();
      drive(32'h48, 0, 0, 1, 0, 0);
      check("t2_i_fetch", i_fetch, 32'h2409_0007);
      tick();

      // Response arrives under a 3-cycle stall.
      drive(32'h48, 1, 0, 0, 1, 32'h8C09_0004); tick();
      for (int h = 1; h <= 3; h++) begin
         drive(32'h48, (h < 3), 0, 1, 0, 0);
         check("t3_valid", 32'(fetch_valid), 32'h1);
         check("t3_i_fetch", i_fetch, 32'h8C09_0004);
         check("t3_no_req", 32'(imem_req_valid), 32'h0);
         tick();
      end
      drive(32'h4C, 0, 0, 1, 0, 0);
      check("t3_req_again", 32'(imem_req_valid), 32'h1);
      check("t3_valid_off", 32'(fetch_valid), 32'h0);
      tick();

      // Flush while waiting; the late response must be dropped.
      drive(32'h100, 0, 1, 0, 0, 0); tick();
      drive(32'h100, 0, 0, 0, 0, 0); tick();
      drive(32'h100, 0, 0, 0, 1, 32'h1000_FFFF);
      check("t4_hold", 32'(pc_hold), 32'h1);
      tick();
      drive(32'h100, 0, 0, 1, 0, 0);
      check("t4_valid", 32'(fetch_valid), 32'h0);
      check("t4_req", 32'(imem_req_valid), 32'h1);
      check("t4_addr", imem_req_addr, 32'h100);
      tick();

      // No response for 70 cycles.
      for (int i = 1; i <= 70; i++) begin
         drive(32'h104, 0, 0, 0, 0, 0);
         if (i == 64) check("t5_tmo_64", 32'(timeout_err), 32'h0);
         if (i == 65) check("t5_tmo_65", 32'(timeout_err), 32'h1);
         if (i == 70) check("t5_tmo_70", 32'(timeout_err), 32'h1);
         tick();
      end
      drive(32'h104, 0, 0, 0, 1, 32'h0123_4567); tick();
      drive(32'h104, 0, 0, 0, 0, 0);
      check("t5_sticky", 32'(timeout_err), 32'h1);
      tick();

      // Misaligned pc, then reset mid-wait and a late response.
      do_reset();
      drive(32'h42, 0, 0, 0, 0, 0); tick();
      drive(32'h42, 0, 0, 1, 0, 0);
      check("t6_addr", imem_req_addr, 32'h40);
      tick();
      drive(32'h42, 0, 0, 0, 0, 0);
      check("t6_misalign", 32'(misalign_err), 32'h1);
      tick();
      do_reset();
      drive(32'h80, 0, 0, 0, 1, 32'hDEAD_BEEF); tick();
      drive(32'h80, 0, 0, 0, 0, 0);
      check("t6_late_ignored", 32'(fetch_valid), 32'h0);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         logic        rv;
         logic [31:0] rd;
         logic [31:0] np;
         logic        st;
         logic        fl;
         logic        rdy;
         if ($urandom % 400 == 0) begin
            do_reset();
         end else begin
            rv = 0;
            rd = $urandom;
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  rv = 1;
                  rd = pend_data;
               end
            end else if ($urandom % 20 == 0) begin
               rv = 1;
            end
            st  = ($urandom % 4 == 0);
            fl  = ($urandom % 16 == 0);
            rdy = ($urandom % 3 != 0);
            np  = pc;
            if (fl || ($urandom % 4 == 0)) np = $urandom & 32'hFFFF_FFFC;
            drive(np, st, fl, rdy, rv, rd);
            if (imem_req_valid && rdy) begin
               pend      = 32'($urandom_range(1, 6));
               pend_data = $urandom;
            end
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
